// File: rtl/cpu_types_pkg.sv
// Shared datapath types and constants for the CPU pipeline stages.
package cpu_types_pkg;

   localparam int WORD_W  = 32;
   localparam int PC_STEP = 4;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      HALTED
   } fetch_state_t;

endpackage : cpu_types_pkg

// File: rtl/fetch_hold_buf.sv
// Single-entry skid buffer that keeps one fetched instruction and its PC+4
// while decode is stalled.
module fetch_hold_buf
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = cpu_types_pkg::WORD_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              load_i,
   input  logic              drain_i,
   input  logic              clear_i,
   input  logic [WORD_W-1:0] instr_i,
   input  logic [WORD_W-1:0] npc_i,
   output logic [WORD_W-1:0] instr_o,
   output logic [WORD_W-1:0] npc_o,
   output logic              full_o
);

   logic [WORD_W-1:0] instr_q;
   logic [WORD_W-1:0] npc_q;
   logic              full_q;

   // NOTE: only the full flag is reset; the data registers are qualified by it
   // and never read while empty, so they need no reset.
   always_ff @(posedge CLK) begin
      if (RST || clear_i || drain_i) begin
         full_q <= 1'b0;
      end else if (load_i) begin
         full_q <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (load_i) begin
         instr_q <= instr_i;
         npc_q   <= npc_i;
      end
   end

   assign instr_o = instr_q;
   assign npc_o   = npc_q;
   assign full_o  = full_q;

endmodule : fetch_hold_buf

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues cache reads for pc_i, fills the IF/ID
// register, strobes the PC, and handles stall, flush and halt.
module instr_fetch_unit
   import cpu_types_pkg::*;
#(
   parameter int WORD_W  = cpu_types_pkg::WORD_W,
   parameter int PC_STEP = cpu_types_pkg::PC_STEP
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WORD_W-1:0] pc_i,
   output logic              pc_en,
   output logic              imemREN,
   output logic [WORD_W-1:0] imemaddr,
   input  logic              ihit,
   input  logic [WORD_W-1:0] imemload,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              halt_i,
   output logic [WORD_W-1:0] instr_o,
   output logic [WORD_W-1:0] npc_o,
   output logic              valid_o
);

   fetch_state_t      state_q, state_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic [WORD_W-1:0] npc_q, npc_d;
   logic              valid_q, valid_d;

   logic              buf_load, buf_drain, buf_clear, buf_full;
   logic [WORD_W-1:0] buf_instr, buf_npc;
   logic [WORD_W-1:0] npc_calc;
   logic              fetch_ok;

   assign npc_calc = pc_i + WORD_W'(PC_STEP);
   assign imemaddr = {pc_i[WORD_W-1:2], 2'b00};

   // Reset also gates the strobes so an ihit during reset never advances the PC.
   assign fetch_ok = (state_q == FETCH) && !flush_i && !halt_i && !RST;
   assign imemREN  = fetch_ok;
   assign pc_en    = fetch_ok && ihit;

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      npc_d     = npc_q;
      valid_d   = valid_q;
      buf_load  = 1'b0;
      buf_drain = 1'b0;
      buf_clear = 1'b0;

      if (halt_i) begin
         state_d   = HALTED;
         valid_d   = 1'b0;
         buf_clear = 1'b1;
      end else if (state_q == HALTED) begin
         valid_d = 1'b0;
      end else if (flush_i) begin
         state_d   = FETCH;
         valid_d   = 1'b0;
         buf_clear = 1'b1;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (ihit && !stall_i) begin
                  instr_d = imemload;
                  npc_d   = npc_calc;
                  valid_d = 1'b1;
               end else if (ihit) begin
                  buf_load = 1'b1;
                  state_d  = HOLD;
               end else if (!stall_i) begin
                  valid_d = 1'b0;
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  instr_d   = buf_instr;
                  npc_d     = buf_npc;
                  valid_d   = buf_full;
                  buf_drain = 1'b1;
                  state_d   = FETCH;
               end
            end
            default: state_d = HALTED;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from values sampled before the edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= FETCH;
         instr_q <= '0;
         npc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         npc_q   <= npc_d;
         valid_q <= valid_d;
      end
   end

   fetch_hold_buf #(
      .WORD_W (WORD_W)
   ) u_hold_buf (
      .CLK     (CLK),
      .RST     (RST),
      .load_i  (buf_load),
      .drain_i (buf_drain),
      .clear_i (buf_clear),
      .instr_i (imemload),
      .npc_i   (npc_calc),
      .instr_o (buf_instr),
      .npc_o   (buf_npc),
      .full_o  (buf_full)
   );

   assign instr_o = instr_q;
   assign npc_o   = npc_q;
   assign valid_o = valid_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: reset, streaming, stall capture,
// flush, PC wrap and halt.
module tb_instr_fetch_unit;

   localparam int W = 32;

   logic         CLK = 1'b0;
   logic         RST;
   logic [W-1:0] pc_i;
   logic         pc_en;
   logic         imemREN;
   logic [W-1:0] imemaddr;
   logic         ihit;
   logic [W-1:0] imemload;
   logic         stall_i;
   logic         flush_i;
   logic         halt_i;
   logic [W-1:0] instr_o;
   logic [W-1:0] npc_o;
   logic         valid_o;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit dut (
      .CLK      (CLK),
      .RST      (RST),
      .pc_i     (pc_i),
      .pc_en    (pc_en),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .ihit     (ihit),
      .imemload (imemload),
      .stall_i  (stall_i),
      .flush_i  (flush_i),
      .halt_i   (halt_i),
      .instr_o  (instr_o),
      .npc_o    (npc_o),
      .valid_o  (valid_o)
   );

   always #5 CLK = ~CLK;

   // Advance one clock; outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; ihit = 1'b1; imemload = 32'hDEADBEEF; pc_i = 32'h40;
      stall_i = 1'b0; flush_i = 1'b0; halt_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (valid_o !== 1'b0 || instr_o !== 32'h0 || npc_o !== 32'h0 || pc_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_cyc%0d: valid=%b instr=%h npc=%h pc_en=%b, want 0/0/0/0",
                     i, valid_o, instr_o, npc_o, pc_en);
         end
      end
      RST = 1'b0; ihit = 1'b0;
      #1;
      checks++;
      if (imemREN !== 1'b1 || pc_en !== 1'b0 || valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: imemREN=%b pc_en=%b valid=%b, want 1/0/0",
                  imemREN, pc_en, valid_o);
      end
   endtask

   task automatic test_stream();
      pc_i = 32'h40; ihit = 1'b1; imemload = 32'h8C220004;
      #1;
      checks++;
      if (pc_en !== 1'b1 || imemaddr !== 32'h40) begin
         errors++;
         $display("FAIL stream_pc_en: pc_en=%b addr=%h, want 1/00000040", pc_en, imemaddr);
      end
      step();
      checks++;
      if (instr_o !== 32'h8C220004 || npc_o !== 32'h44 || valid_o !== 1'b1) begin
         errors++;
         $display("FAIL stream_ifid: instr=%h npc=%h valid=%b, want 8c220004/00000044/1",
                  instr_o, npc_o, valid_o);
      end
      ihit = 1'b0;
      step();
      checks++;
      if (valid_o !== 1'b0 || instr_o !== 32'h8C220004) begin
         errors++;
         $display("FAIL stream_bubble: valid=%b instr=%h, want 0/8c220004", valid_o, instr_o);
      end
   endtask

   task automatic test_stall();
      int pulses = 0;
      pc_i = 32'h100; ihit = 1'b1; imemload = 32'h00221820; stall_i = 1'b1;
      #1;
      if (pc_en === 1'b1) pulses++;
      step();
      ihit = 1'b0; imemload = 32'h0;
      for (int i = 0; i < 2; i++) begin
         #1;
         if (pc_en === 1'b1) pulses++;
         checks++;
         if (imemREN !== 1'b0 || instr_o !== 32'h8C220004 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: imemREN=%b instr=%h valid=%b, want 0/8c220004/0",
                     i, imemREN, instr_o, valid_o);
         end
         step();
      end
      stall_i = 1'b0;
      #1;
      if (pc_en === 1'b1) pulses++;
      step();
      checks++;
      if (instr_o !== 32'h00221820 || npc_o !== 32'h104 || valid_o !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: instr=%h npc=%h valid=%b, want 00221820/00000104/1",
                  instr_o, npc_o, valid_o);
      end
      checks++;
      if (pulses != 1 || imemREN !== 1'b1) begin
         errors++;
         $display("FAIL stall_pc_en: pulses=%0d imemREN=%b, want 1/1", pulses, imemREN);
      end
   endtask

   task automatic test_flush();
      pc_i = 32'h200; ihit = 1'b1; imemload = 32'h11111111; stall_i = 1'b1;
      step();
      ihit = 1'b0; flush_i = 1'b1;
      #1;
      checks++;
      if (imemREN !== 1'b0 || pc_en !== 1'b0) begin
         errors++;
         $display("FAIL flush_hold_strobes: imemREN=%b pc_en=%b, want 0/0", imemREN, pc_en);
      end
      step();
      flush_i = 1'b0; stall_i = 1'b0; pc_i = 32'h303;
      #1;
      checks++;
      if (valid_o !== 1'b0 || imemREN !== 1'b1 || imemaddr !== 32'h300) begin
         errors++;
         $display("FAIL flush_resume: valid=%b imemREN=%b addr=%h, want 0/1/00000300",
                  valid_o, imemREN, imemaddr);
      end
      step();
      checks++;
      if (valid_o !== 1'b0 || instr_o !== 32'h00221820) begin
         errors++;
         $display("FAIL flush_buf_empty: valid=%b instr=%h, want 0/00221820", valid_o, instr_o);
      end
      flush_i = 1'b1; ihit = 1'b1; imemload = 32'h22222222;
      #1;
      checks++;
      if (pc_en !== 1'b0 || imemREN !== 1'b0) begin
         errors++;
         $display("FAIL flush_ihit_strobes: pc_en=%b imemREN=%b, want 0/0", pc_en, imemREN);
      end
      step();
      checks++;
      if (valid_o !== 1'b0 || instr_o !== 32'h00221820) begin
         errors++;
         $display("FAIL flush_ihit_ifid: valid=%b instr=%h, want 0/00221820", valid_o, instr_o);
      end
      flush_i = 1'b0; ihit = 1'b0;
   endtask

   task automatic test_wrap_halt();
      pc_i = 32'hFFFFFFFC; ihit = 1'b1; imemload = 32'hAABBCCDD; stall_i = 1'b0;
      step();
      checks++;
      if (npc_o !== 32'h0 || instr_o !== 32'hAABBCCDD || valid_o !== 1'b1) begin
         errors++;
         $display("FAIL wrap: npc=%h instr=%h valid=%b, want 00000000/aabbccdd/1",
                  npc_o, instr_o, valid_o);
      end
      halt_i = 1'b1; flush_i = 1'b1;
      #1;
      checks++;
      if (imemREN !== 1'b0 || pc_en !== 1'b0) begin
         errors++;
         $display("FAIL halt_strobes: imemREN=%b pc_en=%b, want 0/0", imemREN, pc_en);
      end
      step();
      halt_i = 1'b0; flush_i = 1'b0; pc_i = 32'h500;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if (imemREN !== 1'b0 || pc_en !== 1'b0 || valid_o !== 1'b0 || instr_o !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL halted_cyc%0d: imemREN=%b pc_en=%b valid=%b instr=%h, want 0/0/0/aabbccdd",
                     i, imemREN, pc_en, valid_o, instr_o);
         end
         step();
      end
      RST = 1'b1;
      step();
      RST = 1'b0; ihit = 1'b0;
      #1;
      checks++;
      if (imemREN !== 1'b1 || valid_o !== 1'b0 || instr_o !== 32'h0 || npc_o !== 32'h0) begin
         errors++;
         $display("FAIL halt_reset: imemREN=%b valid=%b instr=%h npc=%h, want 1/0/0/0",
                  imemREN, valid_o, instr_o, npc_o);
      end
      ihit = 1'b1; imemload = 32'h12345678;
      step();
      checks++;
      if (instr_o !== 32'h12345678 || npc_o !== 32'h504 || valid_o !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_fetch: instr=%h npc=%h valid=%b, want 12345678/00000504/1",
                  instr_o, npc_o, valid_o);
      end
      ihit = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_wrap_halt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_instr_fetch_unit
